maxpool2d_stream: RTL and testbench

Streaming, parametrised 2D max-pooling stage for the BCNN datapath. It consumes a raster-scanned feature map of signed Q4.8 (default) pixels, with CH channels carried in parallel lanes, and emits one maximum per non-overlapping POOL×POOL window per channel. Both sides use valid/ready handshakes, and frame boundaries are marked with last flags. It sits between a convolution/activation stage and the next layer, replacing the fixed 4-sample, single-window pooler.

---
 rtl/maxpool_pkg.sv | 35 +++
 rtl/maxpool_row_buf.sv | 37 +++
 rtl/maxpool2d_stream.sv | 191 +++++++++++++++++++
 tb/tb_maxpool2d_stream.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool_pkg.sv
// Shared definitions for the streaming max-pool stage.
//   DATA_W_DEF / FRAC_BITS : default pixel format (Q4.8)
//   MAX_W                  : widest pixel the compare helper supports
//   state_t                : frame-level FSM states
//   max_ge()               : a >= b for w-bit pixels, signed or unsigned
package maxpool_pkg;

  localparam int unsigned DATA_W_DEF = 12;
  localparam int unsigned FRAC_BITS  = 8;
  localparam int unsigned MAX_W      = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  // Operands arrive zero-extended to MAX_W. For a signed compare the sign
  // bit is flipped (offset binary), which turns it into an unsigned compare.
  function automatic logic max_ge(input logic [MAX_W-1:0] a,
                                  input logic [MAX_W-1:0] b,
                                  input int unsigned      w,
                                  input logic             sgn);
    logic [MAX_W-1:0] x;
    logic [MAX_W-1:0] y;
    x = a;
    y = b;
    if (sgn) begin
      x[w-1] = ~x[w-1];
      y[w-1] = ~y[w-1];
    end
    return x >= y;
  endfunction

endpackage

// File: rtl/maxpool_row_buf.sv
// Row buffer holding the partial vertical maximum of each pooling window
// column across the rows of the current window band.
//   clk, rst : clock, asynchronous active-high reset (clears all entries)
//   i_we     : write enable
//   i_waddr  : write address (window column)
//   i_wdata  : write data, all lanes packed
//   i_raddr  : read address (window column)
//   o_rdata  : combinational read data
module maxpool_row_buf
  import maxpool_pkg::*;
#(
  parameter int unsigned DEPTH = 14,
  parameter int unsigned WIDTH = 12,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/maxpool2d_stream.sv
// Streaming non-overlapping POOLxPOOL max-pooling over a raster-scanned
// feature map with CH parallel lanes.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : input pixel handshake
//   in_data, in_last    : pixel vector (lane c at [c*DATA_W +: DATA_W]), frame end
//   out_valid/out_ready : pooled result handshake
//   out_data, out_last  : pooled vector, final window of frame
//   finish              : one-cycle pulse after the out_last beat is accepted
//   frame_err           : sticky in_last misplacement flag
module maxpool2d_stream
  import maxpool_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CH     = 1,
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28,
  parameter int unsigned POOL   = 2,
  parameter int unsigned SIGNED = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH*DATA_W-1:0] in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH*DATA_W-1:0] out_data,
  output logic                 out_last,
  output logic                 finish,
  output logic                 frame_err
);

  localparam int unsigned NWIN = IMG_W / POOL;
  localparam int unsigned AW   = (NWIN  > 1) ? $clog2(NWIN)  : 1;
  localparam int unsigned CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned PW   = (POOL  > 1) ? $clog2(POOL)  : 1;
  localparam int unsigned VW   = CH * DATA_W;

  if (IMG_W % POOL != 0) begin : g_bad_w
    $fatal(1, "IMG_W must be a multiple of POOL");
  end
  if (IMG_H % POOL != 0) begin : g_bad_h
    $fatal(1, "IMG_H must be a multiple of POOL");
  end
  if (DATA_W > MAX_W) begin : g_bad_dw
    $fatal(1, "DATA_W exceeds compare helper width");
  end

  function automatic logic [DATA_W-1:0] lmax(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    return max_ge(MAX_W'(a), MAX_W'(b), DATA_W, SIGNED != 0) ? a : b;
  endfunction

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [PW-1:0] r_wx, r_wy;
  logic [AW-1:0] r_cx;
  logic [VW-1:0] r_hacc;
  logic [VW-1:0] r_out_data;
  logic          r_out_valid, r_out_last, r_finish, r_frame_err;

  logic          w_accept, w_out_fire, w_hend, w_vend, w_col_end, w_final;
  logic          w_abort, w_win, w_we;
  logic [VW-1:0] w_h, w_wdata, w_rdata;

  assign in_ready   = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;
  assign w_hend     = (r_wx == PW'(POOL - 1));
  assign w_vend     = (r_wy == PW'(POOL - 1));
  assign w_col_end  = (r_col == CW'(IMG_W - 1));
  assign w_final    = w_col_end && (r_row == RW'(IMG_H - 1));
  // An early in_last discards the partial frame, including any window it completes.
  assign w_abort    = w_accept && in_last && !w_final;
  assign w_win      = w_accept && w_hend && w_vend && !w_abort;
  assign w_we       = w_accept && w_hend && !w_abort;

  // Per-lane horizontal max and vertical merge; the merged value is both the
  // row-buffer update and, on the last window row, the pooled result.
  always_comb begin : p_lane
    logic [DATA_W-1:0] v_px, v_hv;
    w_h     = '0;
    w_wdata = '0;
    v_px    = '0;
    v_hv    = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      v_px = in_data[c*DATA_W +: DATA_W];
      v_hv = (r_wx == '0) ? v_px : lmax(r_hacc[c*DATA_W +: DATA_W], v_px);
      w_h[c*DATA_W +: DATA_W]     = v_hv;
      w_wdata[c*DATA_W +: DATA_W] = (r_wy == '0) ? v_hv
                                    : lmax(w_rdata[c*DATA_W +: DATA_W], v_hv);
    end
  end

  maxpool_row_buf #(
    .DEPTH(NWIN),
    .WIDTH(VW),
    .AW   (AW)
  ) u_row_buf (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_we),
    .i_waddr(r_cx),
    .i_wdata(w_wdata),
    .i_raddr(r_cx),
    .o_rdata(w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col  <= '0;
      r_row  <= '0;
      r_wx   <= '0;
      r_wy   <= '0;
      r_cx   <= '0;
      r_hacc <= '0;
    end else if (w_accept) begin
      if (w_abort || w_final) begin
        r_col  <= '0;
        r_row  <= '0;
        r_wx   <= '0;
        r_wy   <= '0;
        r_cx   <= '0;
        r_hacc <= '0;
      end else begin
        r_hacc <= w_h;
        if (w_hend) begin
          r_wx <= '0;
          if (w_col_end) begin
            r_col <= '0;
            r_cx  <= '0;
            r_row <= r_row + 1'b1;
            r_wy  <= w_vend ? '0 : r_wy + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
            r_cx  <= r_cx + 1'b1;
          end
        end else begin
          r_wx  <= r_wx + 1'b1;
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_finish    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_finish <= w_out_fire && r_out_last;
      if (w_accept && (in_last != w_final)) r_frame_err <= 1'b1;
      if (w_win) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_wdata;
        r_out_last  <= w_final;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (r_state == DRAIN && w_out_fire && r_out_last) w_state_nx = IDLE;
    if (w_accept) begin
      if (w_abort)      w_state_nx = IDLE;
      else if (w_final) w_state_nx = DRAIN;
      else              w_state_nx = RUN;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign finish    = r_finish;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_maxpool2d_stream.sv
module tb_maxpool2d_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_fin_a  = 0;

  // Instance A: 4x4, POOL=2, two signed lanes (lane1 = ~lane0)
  logic        a_in_valid = 1'b0, a_in_last = 1'b0, a_out_ready = 1'b1;
  logic [23:0] a_in_data = '0;
  logic        a_in_ready, a_out_valid, a_out_last, a_finish, a_frame_err;
  logic [23:0] a_out_data;

  // Instances S/U: 2x2, one lane, signed vs unsigned, shared inputs
  logic        b_in_valid = 1'b0, b_in_last = 1'b0, b_out_ready = 1'b1;
  logic [11:0] b_in_data = '0;
  logic        s_in_ready, s_out_valid, s_out_last, s_finish, s_frame_err;
  logic        u_in_ready, u_out_valid, u_out_last, u_finish, u_frame_err;
  logic [11:0] s_out_data, u_out_data;

  maxpool2d_stream #(.DATA_W(12), .CH(2), .IMG_W(4), .IMG_H(4), .POOL(2), .SIGNED(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_last(a_in_last), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_last(a_out_last), .finish(a_finish), .frame_err(a_frame_err));

  maxpool2d_stream #(.DATA_W(12), .CH(1), .IMG_W(2), .IMG_H(2), .POOL(2), .SIGNED(1)) u_s (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(s_in_ready), .in_data(b_in_data),
    .in_last(b_in_last), .out_valid(s_out_valid), .out_ready(b_out_ready), .out_data(s_out_data),
    .out_last(s_out_last), .finish(s_finish), .frame_err(s_frame_err));

  maxpool2d_stream #(.DATA_W(12), .CH(1), .IMG_W(2), .IMG_H(2), .POOL(2), .SIGNED(0)) u_u (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(u_in_ready), .in_data(b_in_data),
    .in_last(b_in_last), .out_valid(u_out_valid), .out_ready(b_out_ready), .out_data(u_out_data),
    .out_last(u_out_last), .finish(u_finish), .frame_err(u_frame_err));

  // Expected responses: {last, data}
  logic [24:0] qa[$];
  logic [12:0] qs[$];
  logic [12:0] qu[$];
  logic [24:0] ea;
  logic [12:0] es, eu;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  // Scoreboard monitors: sample between edges, pop on each accepted beat
  always @(negedge clk) begin
    if (!rst) begin
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) chk("a_unexpected_beat", 32'({a_out_last, a_out_data}), 32'hDEAD);
        else begin
          ea = qa.pop_front();
          chk("a_out", 32'({a_out_last, a_out_data}), 32'(ea));
        end
      end
      if (s_out_valid && b_out_ready) begin
        if (qs.size() == 0) chk("s_unexpected_beat", 32'({s_out_last, s_out_data}), 32'hDEAD);
        else begin
          es = qs.pop_front();
          chk("s_out", 32'({s_out_last, s_out_data}), 32'(es));
        end
      end
      if (u_out_valid && b_out_ready) begin
        if (qu.size() == 0) chk("u_unexpected_beat", 32'({u_out_last, u_out_data}), 32'hDEAD);
        else begin
          eu = qu.pop_front();
          chk("u_out", 32'({u_out_last, u_out_data}), 32'(eu));
        end
      end
      if (a_finish) n_fin_a++;
    end
  end

  task automatic a_send(input logic [23:0] d, input logic l);
    bit ok;
    int unsigned t;
    a_in_valid = 1'b1;
    a_in_data  = d;
    a_in_last  = l;
    t = 0;
    do begin
      @(negedge clk);
      ok = a_in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!ok && t < 100);
    if (!ok) chk("a_send_timeout", 32'(ok), 32'd1);
    a_in_valid = 1'b0;
    a_in_last  = 1'b0;
  endtask

  task automatic a_pix(input int p, input logic l);
    logic [11:0] v;
    v = 12'(p);
    a_send({~v, v}, l);
  endtask

  task automatic b_send(input logic [11:0] d, input logic l);
    bit ok;
    int unsigned t;
    b_in_valid = 1'b1;
    b_in_data  = d;
    b_in_last  = l;
    t = 0;
    do begin
      @(negedge clk);
      ok = s_in_ready && u_in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!ok && t < 100);
    if (!ok) chk("b_send_timeout", 32'(ok), 32'd1);
    b_in_valid = 1'b0;
    b_in_last  = 1'b0;
  endtask

  // Hand-computed results for pixels 1..16 on the 4x4 map: lane0 = window max,
  // lane1 = max of inverted values = ~(window min)
  task automatic push_basic();
    qa.push_back({1'b0, 12'hFFE, 12'h006});
    qa.push_back({1'b0, 12'hFFC, 12'h008});
    qa.push_back({1'b0, 12'hFF6, 12'h00E});
    qa.push_back({1'b1, 12'hFF4, 12'h010});
  endtask

  task automatic a_frame();
    for (int p = 1; p <= 16; p++) a_pix(p, p == 16);
  endtask

  task automatic drain(input string nm);
    int unsigned t;
    t = 0;
    while ((qa.size() != 0 || qs.size() != 0 || qu.size() != 0) && t < 200) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk(nm, 32'(qa.size() + qs.size() + qu.size()), 32'd0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_in_ready"},  32'(a_in_ready),  32'd1);
    chk({nm, "_out_valid"}, 32'(a_out_valid), 32'd0);
    chk({nm, "_out_data"},  32'(a_out_data),  32'd0);
    chk({nm, "_out_last"},  32'(a_out_last),  32'd0);
    chk({nm, "_finish"},    32'(a_finish),    32'd0);
    chk({nm, "_frame_err"}, 32'(a_frame_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk_reset_vals("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic frame
    push_basic();
    a_frame();
    drain("basic_drain");
    chk("basic_finish_count", 32'(n_fin_a), 32'd1);
    chk("basic_frame_err", 32'(a_frame_err), 32'd0);

    // Backpressure on the first result
    a_out_ready = 1'b0;
    push_basic();
    fork
      a_frame();
      begin
        int unsigned t;
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!a_out_valid && t < 100);
        chk("bp_first_valid", 32'(a_out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
          chk("bp_in_ready", 32'(a_in_ready), 32'd0);
          chk("bp_hold_data", 32'(a_out_data), 32'hFFE006);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
      end
    join
    drain("bp_drain");
    chk("bp_finish_count", 32'(n_fin_a), 32'd2);

    // Asynchronous reset mid-frame
    a_out_ready = 1'b0;
    for (int p = 1; p <= 6; p++) a_pix(p, 1'b0);
    @(negedge clk);
    chk("rst_pre_valid", 32'(a_out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("rst_mid");
    @(posedge clk);
    #1;
    rst = 1'b0;
    a_out_ready = 1'b1;
    push_basic();
    a_frame();
    drain("rst_drain");
    chk("rst_finish_count", 32'(n_fin_a), 32'd3);

    // Early in_last on pixel 10: the two completed windows still emerge
    qa.push_back({1'b0, 12'hFFE, 12'h006});
    qa.push_back({1'b0, 12'hFFC, 12'h008});
    for (int p = 1; p <= 10; p++) a_pix(p, p == 10);
    drain("early_drain");
    chk("early_frame_err", 32'(a_frame_err), 32'd1);
    push_basic();
    a_frame();
    drain("early_next_drain");
    chk("early_err_sticky", 32'(a_frame_err), 32'd1);
    chk("early_finish_count", 32'(n_fin_a), 32'd4);

    // Signed vs unsigned compare on single-window 2x2 frames
    qs.push_back({1'b1, 12'hFFF});
    qu.push_back({1'b1, 12'hFFF});
    b_send(12'hF00, 1'b0);
    b_send(12'h800, 1'b0);
    b_send(12'hFFF, 1'b0);
    b_send(12'hE00, 1'b1);
    qs.push_back({1'b1, 12'h7FF});
    qu.push_back({1'b1, 12'h800});
    b_send(12'h7FF, 1'b0);
    b_send(12'h800, 1'b0);
    b_send(12'h000, 1'b0);
    b_send(12'h000, 1'b1);
    drain("cmp_drain");
    chk("cmp_frame_err", 32'({s_frame_err, u_frame_err}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
